// File: rtl/serial_twos_decoder_if.sv
// Serial two's-complement decoder bus: start/serial bit stream in, decoded word out.
interface serial_twos_decoder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             din;
    logic             din_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] mag;
    logic             sign;
    logic [WIDTH-1:0] ones;
    logic             min_neg;

    modport master (
        output start, din, din_valid,
        input  busy, done, mag, sign, ones, min_neg
    );

    modport slave (
        input  start, din, din_valid,
        output busy, done, mag, sign, ones, min_neg
    );
endinterface

// File: rtl/serial_twos_decoder.sv
// Receives a WIDTH-bit two's-complement word LSB first and reports magnitude, sign, 1's complement.
// Result registers update on the edge into DONE, so done and the outputs appear together.
module serial_twos_decoder #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_twos_decoder_if.slave bus
);
    localparam int               CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] raw, raw_nxt;
    logic [WIDTH-1:0] neg, neg_nxt;
    logic             seen_one, seen_nxt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] mag_q;
    logic             sign_q;
    logic [WIDTH-1:0] ones_q;
    logic             min_neg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // neg is built by serial negation: copy bits up to the first 1, invert everything after it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        raw_nxt   = raw;
        neg_nxt   = neg;
        seen_nxt  = seen_one;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RECV;
                    cnt_nxt   = '0;
                    raw_nxt   = '0;
                    neg_nxt   = '0;
                    seen_nxt  = 1'b0;
                end
            end
            RECV: begin
                if (bus.din_valid) begin
                    raw_nxt  = {bus.din, raw[WIDTH-1:1]};
                    neg_nxt  = {(seen_one ? ~bus.din : bus.din), neg[WIDTH-1:1]};
                    seen_nxt = seen_one | bus.din;
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == LAST) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            raw       <= '0;
            neg       <= '0;
            seen_one  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mag_q     <= '0;
            sign_q    <= 1'b0;
            ones_q    <= '0;
            min_neg_q <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            raw      <= raw_nxt;
            neg      <= neg_nxt;
            seen_one <= seen_nxt;
            busy_q   <= (state_nxt == RECV);
            done_q   <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                mag_q     <= raw_nxt[WIDTH-1] ? neg_nxt : raw_nxt;
                sign_q    <= raw_nxt[WIDTH-1];
                ones_q    <= ~raw_nxt;
                min_neg_q <= (raw_nxt == MIN_NEG);
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.mag     = mag_q;
    assign bus.sign    = sign_q;
    assign bus.ones    = ones_q;
    assign bus.min_neg = min_neg_q;
endmodule

// File: tb/tb_serial_twos_decoder.sv
// Self-checking bench for serial_twos_decoder with an arithmetic reference model.
module tb_serial_twos_decoder;
    localparam int W    = 4;
    localparam int HALF = 1 << (W - 1);
    localparam int FULL = 1 << W;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   done_count = 0;

    always #5 clk = ~clk;

    serial_twos_decoder_if #(.WIDTH(W)) bus ();

    serial_twos_decoder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (bus.done === 1'b1) done_count <= done_count + 1;

    // Reference: interpret the word as a signed integer and take its absolute value.
    function automatic int ref_value(input int w);
        return (w >= HALF) ? w - FULL : w;
    endfunction
    function automatic logic [W-1:0] ref_mag(input int w);
        int v = ref_value(w);
        return W'((v < 0) ? -v : v);
    endfunction
    function automatic logic ref_sign(input int w);
        return ref_value(w) < 0;
    endfunction
    function automatic logic [W-1:0] ref_ones(input int w);
        return W'(FULL - 1 - w);
    endfunction
    function automatic logic ref_min(input int w);
        return ref_value(w) == -HALF;
    endfunction

    // Sends one word; tot = edges from the start-sampling edge to the cycle done is seen (-1 if never).
    task automatic send_word(input int w, input int stall_at, input int nstall,
                             input bit noise, output int tot);
        logic [W-1:0] wv = W'(w);
        int cnt = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < W; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < nstall; s++) begin
                    bus.din_valid = 1'b0;
                    bus.din       = 1'($urandom);
                    bus.start     = noise ? 1'($urandom) : 1'b0;
                    @(posedge clk); #1; cnt++;
                end
            end
            bus.din       = wv[k];
            bus.din_valid = 1'b1;
            bus.start     = noise ? 1'($urandom) : 1'b0;
            @(posedge clk); #1; cnt++;
        end
        bus.din_valid = 1'b0;
        bus.start     = 1'b0;
        tot = -1;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) begin
                tot = cnt;
                break;
            end
            @(posedge clk); #1; cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.din = 1'b0; bus.din_valid = 1'b0;
        #12;
        checks++;
        if ({bus.busy, bus.done, bus.mag, bus.sign, bus.ones, bus.min_neg} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b mag=%h sign=%b ones=%h min_neg=%b, expected all 0",
                     bus.busy, bus.done, bus.mag, bus.sign, bus.ones, bus.min_neg);
        end
        @(negedge clk); rst = 1'b0;
        bus.din_valid = 1'b1; bus.din = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_wait: got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic test_vectors;
        int words[5] = '{5, 11, 15, 8, 0};
        int tot, dc0;
        foreach (words[i]) begin
            dc0 = done_count;
            send_word(words[i], -1, 0, 1'b0, tot);
            checks++;
            if (tot !== W) begin
                errors++;
                $display("FAIL vec_latency w=%0d: got %0d, expected %0d", words[i], tot, W);
            end
            checks++;
            if (bus.mag !== ref_mag(words[i]) || bus.sign !== ref_sign(words[i]) ||
                bus.ones !== ref_ones(words[i]) || bus.min_neg !== ref_min(words[i])) begin
                errors++;
                $display("FAIL vec_result w=%0d: got mag=%h sign=%b ones=%h min_neg=%b, expected %h %b %h %b",
                         words[i], bus.mag, bus.sign, bus.ones, bus.min_neg,
                         ref_mag(words[i]), ref_sign(words[i]), ref_ones(words[i]), ref_min(words[i]));
            end
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || done_count !== dc0 + 1) begin
                errors++;
                $display("FAIL vec_pulse w=%0d: got done=%b busy=%b pulses=%0d, expected 0 0 1",
                         words[i], bus.done, bus.busy, done_count - dc0);
            end
        end
    endtask

    task automatic test_stall;
        int tot, dc0;
        dc0 = done_count;
        send_word(4'b1110, 2, 2, 1'b0, tot);
        checks++;
        if (tot !== W + 2) begin
            errors++;
            $display("FAIL stall_latency: got %0d, expected %0d", tot, W + 2);
        end
        checks++;
        if (bus.mag !== 4'b0010 || bus.sign !== 1'b1) begin
            errors++;
            $display("FAIL stall_result: got mag=%h sign=%b, expected 2 1", bus.mag, bus.sign);
        end
        @(posedge clk); #1;
        checks++;
        if (done_count !== dc0 + 1) begin
            errors++;
            $display("FAIL stall_pulses: got %0d, expected 1", done_count - dc0);
        end
    endtask

    task automatic test_hold;
        logic [W-1:0] m = bus.mag;
        logic [W-1:0] o = bus.ones;
        int dc0 = done_count;
        for (int i = 0; i < 4; i++) begin
            bus.din_valid = 1'($urandom);
            bus.din       = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (bus.mag !== m || bus.ones !== o || bus.busy !== 1'b0 || done_count !== dc0) begin
                errors++;
                $display("FAIL hold_idle cycle %0d: got mag=%h ones=%h busy=%b pulses=%0d, expected %h %h 0 0",
                         i, bus.mag, bus.ones, bus.busy, done_count - dc0, m, o);
            end
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        int dc0, cnt;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.din_valid = 1'b1; bus.din = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.mag, bus.sign, bus.ones, bus.min_neg} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got busy=%b mag=%h sign=%b ones=%h, expected all 0",
                     bus.busy, bus.mag, bus.sign, bus.ones);
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.busy, bus.done, bus.mag, bus.sign, bus.ones, bus.min_neg} !== '0) begin
            errors++;
            $display("FAIL midreset_after: got busy=%b done=%b mag=%h ones=%h, expected all 0",
                     bus.busy, bus.done, bus.mag, bus.ones);
        end
        bus.din_valid = 1'b0;
        dc0 = done_count;
        send_word(4'b0011, -1, 0, 1'b0, cnt);
        checks++;
        if (cnt !== W || bus.mag !== 4'b0011 || bus.sign !== 1'b0) begin
            errors++;
            $display("FAIL midreset_word: got lat=%0d mag=%h sign=%b, expected %0d 3 0",
                     cnt, bus.mag, bus.sign, W);
        end
        @(posedge clk); #1;
        checks++;
        if (done_count !== dc0 + 1) begin
            errors++;
            $display("FAIL midreset_pulses: got %0d, expected 1", done_count - dc0);
        end
    endtask

    task automatic test_back_to_back;
        int a = int'($urandom_range(FULL - 1));
        int b = int'($urandom_range(FULL - 1));
        logic [W-1:0] av = W'(a);
        logic [W-1:0] bv = W'(b);
        int dc0 = done_count;
        bit exp_busy, exp_done;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.din_valid = 1'b1;
        @(posedge clk); #1;
        // Cycle c: word a bits in 0..3, DONE at 4, IDLE at 5, word b bits 6..9, DONE at 10.
        for (int c = 0; c < 12; c++) begin
            exp_busy = (c < W) || (c >= W + 2 && c < 2 * W + 2);
            exp_done = (c == W) || (c == 2 * W + 2);
            checks++;
            if (bus.busy !== exp_busy || bus.done !== exp_done) begin
                errors++;
                $display("FAIL b2b_ctrl c=%0d: got busy=%b done=%b, expected %b %b",
                         c, bus.busy, bus.done, exp_busy, exp_done);
            end
            if (c == W || c == 2 * W + 2) begin
                checks++;
                if (bus.mag !== ref_mag(c == W ? a : b) || bus.sign !== ref_sign(c == W ? a : b)) begin
                    errors++;
                    $display("FAIL b2b_result c=%0d: got mag=%h sign=%b, expected %h %b", c,
                             bus.mag, bus.sign, ref_mag(c == W ? a : b), ref_sign(c == W ? a : b));
                end
            end
            if (c < W)                          bus.din = av[c];
            else if (c >= W + 2 && c < 2*W + 2) bus.din = bv[c - W - 2];
            else                                bus.din = 1'($urandom);
            bus.start = (c < 2 * W + 2);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.din_valid = 1'b0;
        checks++;
        if (done_count !== dc0 + 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d, expected 2", done_count - dc0);
        end
    endtask

    task automatic test_random;
        int w, sa, ns, tot, dc0;
        for (int n = 0; n < 30; n++) begin
            w   = int'($urandom_range(FULL - 1));
            sa  = int'($urandom_range(W - 1));
            ns  = int'($urandom_range(3));
            dc0 = done_count;
            send_word(w, sa, ns, 1'b1, tot);
            checks++;
            if (tot !== W + ns) begin
                errors++;
                $display("FAIL rand_latency w=%0d stalls=%0d: got %0d, expected %0d", w, ns, tot, W + ns);
            end
            checks++;
            if (bus.mag !== ref_mag(w) || bus.sign !== ref_sign(w) ||
                bus.ones !== ref_ones(w) || bus.min_neg !== ref_min(w)) begin
                errors++;
                $display("FAIL rand_result w=%0d: got mag=%h sign=%b ones=%h min_neg=%b, expected %h %b %h %b",
                         w, bus.mag, bus.sign, bus.ones, bus.min_neg,
                         ref_mag(w), ref_sign(w), ref_ones(w), ref_min(w));
            end
            @(posedge clk); #1;
            checks++;
            if (done_count !== dc0 + 1) begin
                errors++;
                $display("FAIL rand_pulses w=%0d: got %0d, expected 1", w, done_count - dc0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
